// File: rtl/ifft_loader_pkg.sv
// Shared definitions for the IFFT loader: one-hot state encoding and the
// real/imaginary field positions inside a 64-bit result word.
package ifft_loader_pkg;

   // One-hot state encoding, same style as the main FSM.
   typedef enum logic [5:0] {
      S_IDLE       = 6'b000001,
      S_REQ        = 6'b000010,
      S_WAIT_VALID = 6'b000100,
      S_PUSH       = 6'b001000,
      S_WAIT_IFFT  = 6'b010000,
      S_ERR        = 6'b100000
   } state_t;

   // Field slices of a result word: {re, im}.
   localparam int RE_MSB = 63;
   localparam int RE_LSB = 32;
   localparam int IM_MSB = 31;
   localparam int IM_LSB = 0;

endpackage

// File: rtl/ifft_loader_timeout.sv
// Loadable down-counter with an expired flag. Expired is high whenever the
// count sits at zero; the count stops at zero rather than wrapping.
module ifft_loader_timeout #(
   parameter int MAX_COUNT = 64,
   parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic             expired
);

   logic [CNT_W-1:0] count_reg;

   // Count register: load has priority over counting down.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (enable && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/ifft_loader.sv
// IFFT loader: fetches every spectral bin from the main FSM result port, one
// outstanding read at a time, and streams the words into the IFFT core.
module ifft_loader
   import ifft_loader_pkg::*;
#(
   parameter int N_BINS  = 512,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 64
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W-1:0]   result_address,
   output logic                result_read_enable,
   input  logic                result_read_valid,
   input  logic [DATA_W-1:0]   result_data,
   output logic                ifft_start,
   output logic                ifft_we,
   output logic [DATA_W/2-1:0] ifft_xn_re,
   output logic [DATA_W/2-1:0] ifft_xn_im,
   output logic [ADDR_W-1:0]   ifft_xn_index,
   input  logic                ifft_rfd,
   input  logic                ifft_done
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] idx_reg;
   logic [DATA_W-1:0] hold_reg;
   logic              error_reg;
   logic              done_reg;
   logic              ifft_start_reg;

   logic start_accept;
   logic push_accept;
   logic last_bin;
   logic read_timeout;
   logic tmo_load;
   logic tmo_enable;
   logic tmo_expired;

   assign last_bin     = (idx_reg == ADDR_W'(N_BINS - 1));
   assign start_accept = (state_reg == S_IDLE) && start;
   assign push_accept  = (state_reg == S_PUSH) && ifft_rfd;
   // Valid wins over an expired counter in the same cycle.
   assign read_timeout = (state_reg == S_WAIT_VALID) && !result_read_valid && tmo_expired;

   // Read-latency watchdog: armed during the strobe, counts WAIT_VALID cycles.
   ifft_loader_timeout #(
      .MAX_COUNT (TIMEOUT),
      .CNT_W     (TMO_W)
   ) u_timeout (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (tmo_load),
      .load_value (TMO_W'(TIMEOUT - 1)),
      .enable     (tmo_enable),
      .expired    (tmo_expired)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_next         = state_reg;
      busy               = 1'b0;
      result_read_enable = 1'b0;
      result_address     = '0;
      ifft_we            = 1'b0;
      ifft_xn_re         = '0;
      ifft_xn_im         = '0;
      ifft_xn_index      = '0;
      tmo_load           = 1'b0;
      tmo_enable         = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            busy               = 1'b1;
            result_read_enable = 1'b1;
            result_address     = idx_reg;
            tmo_load           = 1'b1;
            state_next         = S_WAIT_VALID;
         end
         S_WAIT_VALID: begin
            busy       = 1'b1;
            tmo_enable = 1'b1;
            if (result_read_valid) begin
               state_next = S_PUSH;
            end else if (tmo_expired) begin
               state_next = S_ERR;
            end
         end
         S_PUSH: begin
            busy          = 1'b1;
            ifft_we       = 1'b1;
            ifft_xn_re    = hold_reg[RE_MSB:RE_LSB];
            ifft_xn_im    = hold_reg[IM_MSB:IM_LSB];
            ifft_xn_index = idx_reg;
            if (ifft_rfd) begin
               state_next = last_bin ? S_WAIT_IFFT : S_REQ;
            end
         end
         S_WAIT_IFFT: begin
            busy = 1'b1;
            if (ifft_done) begin
               state_next = S_IDLE;
            end
         end
         S_ERR: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: bin index, hold register, sticky error and one-cycle pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_reg        <= '0;
         hold_reg       <= '0;
         error_reg      <= 1'b0;
         done_reg       <= 1'b0;
         ifft_start_reg <= 1'b0;
      end else begin
         done_reg       <= (state_reg == S_WAIT_IFFT) && ifft_done;
         ifft_start_reg <= start_accept;
         if (start_accept) begin
            idx_reg <= '0;
         end else if (push_accept && !last_bin) begin
            idx_reg <= idx_reg + 1'b1;
         end
         if ((state_reg == S_WAIT_VALID) && result_read_valid) begin
            hold_reg <= result_data;
         end
         if (start_accept) begin
            error_reg <= 1'b0;
         end else if (read_timeout) begin
            error_reg <= 1'b1;
         end
      end
   end

   assign done       = done_reg;
   assign error      = error_reg;
   assign ifft_start = ifft_start_reg;

endmodule
